// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM driver and the upstream RGB converter:
// duty width, period length and the colour-word field layout.
package rgb_pwm_pkg;

   localparam int unsigned DUTY_W    = 8;
   localparam int unsigned PWM_STEPS = 255;
   localparam int unsigned RGB_W     = 24;

   localparam int unsigned R_MSB = 23;
   localparam int unsigned R_LSB = 16;
   localparam int unsigned G_MSB = 15;
   localparam int unsigned G_LSB = 8;
   localparam int unsigned B_MSB = 7;
   localparam int unsigned B_LSB = 0;

   typedef struct packed {
      logic [DUTY_W-1:0] r;
      logic [DUTY_W-1:0] g;
      logic [DUTY_W-1:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      CH_R = 2'd0,
      CH_G = 2'd1,
      CH_B = 2'd2
   } channel_e;

   function automatic logic [DUTY_W-1:0] rgb_field(input logic [RGB_W-1:0] rgb,
                                                   input channel_e ch);
      case (ch)
         CH_R:    return rgb[R_MSB:R_LSB];
         CH_G:    return rgb[G_MSB:G_LSB];
         CH_B:    return rgb[B_MSB:B_LSB];
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: shadow duty register, step comparator and registered output.
module pwm_channel
   import rgb_pwm_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              load_i,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic [DUTY_W-1:0] cnt_i,
   output logic              pwm_o
);

   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              pwm_q, pwm_d;

   // The comparator uses the shadow copy, so rgb edits mid-period are invisible
   // until the next load.
   always_comb begin
      duty_d = load_i ? duty_i : duty_q;
      pwm_d  = enable_i && (cnt_i < duty_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel LED PWM with a shared prescaler and 255-step counter; each
// period starts with cnt=0 and uses duties latched at the previous period end.
module rgb_pwm
   import rgb_pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] rgb,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b,
   output logic        period_start
);

   localparam logic [15:0]       PRE_LAST = 16'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_STEPS - 1);

   logic [15:0]       pre_q, pre_d;
   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic              ps_q, ps_d;
   logic              tick;
   logic              period_end;
   logic              load;

   always_comb begin
      tick       = (pre_q == PRE_LAST);
      period_end = tick && (cnt_q == CNT_LAST);
      // While disabled the shadows track rgb every cycle, so re-enabling starts
      // with the most recent colour.
      load       = !enable || period_end;
      pre_d      = '0;
      cnt_d      = '0;
      if (enable) begin
         pre_d = tick ? '0 : pre_q + 16'd1;
         cnt_d = cnt_q;
         if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         end
      end
      ps_d = enable && period_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         cnt_q <= '0;
         ps_q  <= 1'b0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         ps_q  <= ps_d;
      end
   end

   pwm_channel u_ch_r (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .load_i   (load),
      .duty_i   (rgb_field(rgb, CH_R)),
      .cnt_i    (cnt_q),
      .pwm_o    (pwm_r)
   );

   pwm_channel u_ch_g (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .load_i   (load),
      .duty_i   (rgb_field(rgb, CH_G)),
      .cnt_i    (cnt_q),
      .pwm_o    (pwm_g)
   );

   pwm_channel u_ch_b (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .load_i   (load),
      .duty_i   (rgb_field(rgb, CH_B)),
      .cnt_i    (cnt_q),
      .pwm_o    (pwm_b)
   );

   assign period_start = ps_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// Directed bench for rgb_pwm: one PRESCALE=1 instance and one PRESCALE=4 instance.
module tb_rgb_pwm;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        enable4;
   logic [23:0] rgb;
   logic [23:0] rgb4;
   logic        pwm_r, pwm_g, pwm_b, period_start;
   logic        pwm4_r, pwm4_g, pwm4_b, period_start4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rgb_pwm #(.PRESCALE(1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .rgb          (rgb),
      .pwm_r        (pwm_r),
      .pwm_g        (pwm_g),
      .pwm_b        (pwm_b),
      .period_start (period_start)
   );

   rgb_pwm #(.PRESCALE(4)) u_dut4 (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable4),
      .rgb          (rgb4),
      .pwm_r        (pwm4_r),
      .pwm_g        (pwm4_g),
      .pwm_b        (pwm4_b),
      .period_start (period_start4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ps(input int limit, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         step();
         if (period_start) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_wait_period_start: no pulse within %0d cycles", tag, limit);
      end
   endtask

   task automatic measure(input int n, output int hr, output int hg, output int hb,
                          output int ps, output bit ps_end);
      hr = 0; hg = 0; hb = 0; ps = 0; ps_end = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         hr += int'(pwm_r);
         hg += int'(pwm_g);
         hb += int'(pwm_b);
         ps += int'(period_start);
         ps_end = period_start;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; rgb = 24'hFF_FF_FF;
      repeat (3) step();
      checks += 4;
      if (pwm_r !== 1'b0) begin failures++; $display("FAIL reset_pwm_r: got %b want 0", pwm_r); end
      if (pwm_g !== 1'b0) begin failures++; $display("FAIL reset_pwm_g: got %b want 0", pwm_g); end
      if (pwm_b !== 1'b0) begin failures++; $display("FAIL reset_pwm_b: got %b want 0", pwm_b); end
      if (period_start !== 1'b0) begin failures++; $display("FAIL reset_period_start: got %b want 0", period_start); end
   endtask

   task automatic test_basic();
      int hr, hg, hb, ps; bit pe;
      enable = 1'b0; rgb = 24'h80_00_FF;
      step();
      rst = 1'b0;
      repeat (2) step();
      enable = 1'b1;
      wait_ps(300, "basic");
      for (int p = 0; p < 2; p++) begin
         measure(255, hr, hg, hb, ps, pe);
         checks += 5;
         if (hr != 128) begin failures++; $display("FAIL basic_r_high p%0d: got %0d want 128", p, hr); end
         if (hg != 0)   begin failures++; $display("FAIL basic_g_high p%0d: got %0d want 0", p, hg); end
         if (hb != 255) begin failures++; $display("FAIL basic_b_high p%0d: got %0d want 255", p, hb); end
         if (ps != 1)   begin failures++; $display("FAIL basic_ps_count p%0d: got %0d want 1", p, ps); end
         if (pe != 1'b1) begin failures++; $display("FAIL basic_ps_spacing p%0d: got %b want 1 at cycle 255", p, pe); end
      end
   endtask

   task automatic test_shadow();
      int hr, hg, hb, ps; bit pe;
      wait_ps(300, "shadow");
      hr = 0;
      for (int i = 1; i <= 255; i++) begin
         step();
         hr += int'(pwm_r);
         if (i == 100) rgb = 24'h40_00_FF;
      end
      checks++;
      if (hr != 128) begin failures++; $display("FAIL shadow_current_r: got %0d want 128", hr); end
      measure(255, hr, hg, hb, ps, pe);
      checks += 2;
      if (hr != 64) begin failures++; $display("FAIL shadow_next_r: got %0d want 64", hr); end
      if (hb != 255) begin failures++; $display("FAIL shadow_next_b: got %0d want 255", hb); end
   endtask

   task automatic test_boundary();
      int hr, hg, hb, ps; bit pe;
      rgb = 24'h00_01_FE;
      wait_ps(300, "boundary");
      measure(255, hr, hg, hb, ps, pe);
      checks += 4;
      if (hr != 0)   begin failures++; $display("FAIL boundary_r: got %0d want 0", hr); end
      if (hg != 1)   begin failures++; $display("FAIL boundary_g: got %0d want 1", hg); end
      if (hb != 254) begin failures++; $display("FAIL boundary_b: got %0d want 254", hb); end
      if (pe != 1'b1) begin failures++; $display("FAIL boundary_ps_end: got %b want 1", pe); end
   endtask

   task automatic test_enable_drop();
      int hr, hg, hb, ps; bit pe;
      wait_ps(300, "enable_drop");
      repeat (50) step();
      enable = 1'b0; rgb = 24'h20_40_60;
      step();
      checks += 5;
      if (pwm_r !== 1'b0) begin failures++; $display("FAIL drop_pwm_r: got %b want 0", pwm_r); end
      if (pwm_g !== 1'b0) begin failures++; $display("FAIL drop_pwm_g: got %b want 0", pwm_g); end
      if (pwm_b !== 1'b0) begin failures++; $display("FAIL drop_pwm_b: got %b want 0", pwm_b); end
      if (period_start !== 1'b0) begin failures++; $display("FAIL drop_period_start: got %b want 0", period_start); end
      if (u_dut.cnt_q !== 8'd0) begin failures++; $display("FAIL drop_cnt: got %0d want 0", u_dut.cnt_q); end
      repeat (3) step();
      checks++;
      if (pwm_b !== 1'b0) begin failures++; $display("FAIL drop_hold_pwm_b: got %b want 0", pwm_b); end
      enable = 1'b1;
      measure(255, hr, hg, hb, ps, pe);
      checks += 5;
      if (hr != 32) begin failures++; $display("FAIL reenable_r: got %0d want 32", hr); end
      if (hg != 64) begin failures++; $display("FAIL reenable_g: got %0d want 64", hg); end
      if (hb != 96) begin failures++; $display("FAIL reenable_b: got %0d want 96", hb); end
      if (ps != 1)  begin failures++; $display("FAIL reenable_ps_count: got %0d want 1", ps); end
      if (pe != 1'b1) begin failures++; $display("FAIL reenable_ps_end: got %b want 1", pe); end
   endtask

   task automatic test_reset_mid();
      int hr, hg, hb, ps; bit pe;
      wait_ps(300, "reset_mid");
      repeat (80) step();
      rst = 1'b1;
      step();
      checks += 4;
      if (pwm_r !== 1'b0) begin failures++; $display("FAIL rstmid_pwm_r: got %b want 0", pwm_r); end
      if (pwm_g !== 1'b0) begin failures++; $display("FAIL rstmid_pwm_g: got %b want 0", pwm_g); end
      if (pwm_b !== 1'b0) begin failures++; $display("FAIL rstmid_pwm_b: got %b want 0", pwm_b); end
      if (period_start !== 1'b0) begin failures++; $display("FAIL rstmid_period_start: got %b want 0", period_start); end
      step();
      rst = 1'b0;
      measure(255, hr, hg, hb, ps, pe);
      checks += 4;
      if (hr != 0) begin failures++; $display("FAIL rstmid_first_r: got %0d want 0", hr); end
      if (hg != 0) begin failures++; $display("FAIL rstmid_first_g: got %0d want 0", hg); end
      if (hb != 0) begin failures++; $display("FAIL rstmid_first_b: got %0d want 0", hb); end
      if (pe != 1'b1) begin failures++; $display("FAIL rstmid_first_ps_end: got %b want 1", pe); end
      measure(255, hr, hg, hb, ps, pe);
      checks += 3;
      if (hr != 32) begin failures++; $display("FAIL rstmid_second_r: got %0d want 32", hr); end
      if (hg != 64) begin failures++; $display("FAIL rstmid_second_g: got %0d want 64", hg); end
      if (hb != 96) begin failures++; $display("FAIL rstmid_second_b: got %0d want 96", hb); end
   endtask

   task automatic test_prescale4();
      int hr, hg, hb, ps;
      bit ok, pe;
      rgb4 = 24'h80_80_80;
      step();
      enable4 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         step();
         if (period_start4) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL pre4_wait_period_start: no pulse within 2500 cycles"); end
      hr = 0; hg = 0; hb = 0; ps = 0; pe = 1'b0;
      for (int i = 0; i < 1020; i++) begin
         step();
         hr += int'(pwm4_r);
         hg += int'(pwm4_g);
         hb += int'(pwm4_b);
         ps += int'(period_start4);
         pe = period_start4;
      end
      checks += 5;
      if (hr != 512) begin failures++; $display("FAIL pre4_r: got %0d want 512", hr); end
      if (hg != 512) begin failures++; $display("FAIL pre4_g: got %0d want 512", hg); end
      if (hb != 512) begin failures++; $display("FAIL pre4_b: got %0d want 512", hb); end
      if (ps != 1)   begin failures++; $display("FAIL pre4_ps_count: got %0d want 1", ps); end
      if (pe != 1'b1) begin failures++; $display("FAIL pre4_ps_spacing: got %b want 1 at cycle 1020", pe); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; enable4 = 1'b0; rgb = '0; rgb4 = '0;
      test_reset();
      test_basic();
      test_shadow();
      test_boundary();
      test_enable_drop();
      test_reset_mid();
      test_prescale4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgb_pwm.md
RGB_PWM -- requirements
Module: rgb_pwm

Interface
REQ-001 Parameter PRESCALE, default 1: number of clk cycles per PWM step (legal values 1..65535).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run PWM when high; force outputs low and hold counters when low.
REQ-005 rgb  input  24  colour word produced by the upstream RGB converter: R=[23:16], G=[15:8], B=[7:0].
REQ-006 pwm_r  output  1  registered PWM drive for the red LED.
REQ-007 pwm_g  output  1  registered PWM drive for the green LED.
REQ-008 pwm_b  output  1  registered PWM drive for the blue LED.
REQ-009 period_start  output  1  registered one-cycle pulse marking the first step of each PWM period.

Function
REQ-010 The prescaler pre SHALL count 0..PRESCALE-1 while enable=1; tick SHALL be true when pre==PRESCALE-1, and pre SHALL wrap to 0 on tick.
REQ-011 The step counter cnt (8 bit) SHALL advance on tick as 0,1,...,254,0; period = 255 steps = 255*PRESCALE clk cycles.
REQ-012 Shadow duty registers duty_r/g/b SHALL load rgb fields on the tick where cnt==254, and on every cycle while enable=0; rgb changes at any other time SHALL NOT affect the current period.
REQ-013 Each cycle, pwm_x SHALL be registered as enable AND (cnt < duty_x), using pre-edge values; one-cycle latency from cnt/duty to pin.
REQ-014 Duty 0 SHALL give pwm_x constantly low; duty 255 SHALL give pwm_x constantly high; duty d SHALL give exactly d high steps per period, contiguous from cnt=0.
REQ-015 period_start SHALL be registered as enable AND tick AND cnt==254, so it is high in the same cycle cnt reads 0 at the start of each new period.
REQ-016 While enable=0: pre and cnt SHALL be held at 0, pwm_r/g/b and period_start SHALL read 0 on the next edge.
REQ-017 On enable 0->1: the first period SHALL start with cnt=0 and duties equal to rgb sampled in the last enable=0 cycle; no period_start pulse for this first period.
REQ-018 enable dropping mid-period SHALL abandon the period immediately; there is no completion of the partial period.

Reset
REQ-019 On rst=1 at a rising edge: pre=0, cnt=0, duty_r/g/b=0, pwm_r=pwm_g=pwm_b=0, period_start=0.
REQ-020 rst SHALL take priority over enable and tick in the same cycle.
REQ-021 After rst falls with enable=1, the block SHALL behave as the enable 0->1 case of REQ-017, but with duties 0 for the first period.

Structure
REQ-022 A shared package SHALL hold DUTY_W=8, PWM_STEPS=255, and the R/G/B bit-field positions of the 24-bit colour word, for reuse by the upstream converter.
REQ-023 One sub-module pwm_channel (shadow duty register, comparator, output register) SHALL be instantiated three times; prescaler and step counter SHALL live in rgb_pwm and be shared.
REQ-024 No combinational path SHALL exist from any input to any output.

Verification
REQ-025 PRESCALE=1, enable=1, rgb=24'h80_00_FF -> per 255-cycle period pwm_r high 128 cycles, pwm_g always 0, pwm_b always 1; period_start every 255 cycles.
REQ-026 PRESCALE=1, R duty 8'h80 -> change rgb R to 8'h40 at cnt=100 -> current period stays 128 high cycles; next period 64 high cycles.
REQ-027 PRESCALE=4, rgb=24'h80_80_80 -> period 1020 cycles, each channel high 512 cycles, period_start spacing 1020.
REQ-028 enable dropped at cnt=50 -> all outputs 0 on next edge, cnt held at 0; re-enable -> full 255-step period from cnt=0 with freshly sampled rgb.
REQ-029 rst asserted mid-period with enable=1 -> all outputs 0 next edge; after release, first period all channels low, second period follows rgb.
REQ-030 Duty boundaries: rgb=24'h00_01_FE -> pwm_r never high, pwm_g high exactly 1 step, pwm_b high 254 steps and low 1 step per period.
